// File: rtl/tw_modmul_2lane.sv
// Two-lane pipelined Goldilocks modular multiplier (p = 2^64 - 2^32 + 1).
// Sits behind the stage twiddle ROM; each enabled cycle it accepts one
// 128-bit butterfly word and the aligned twiddle word and returns the
// lane-wise canonical product (data*tw) mod p four register stages later.
//
// Ports:
//   CLK       rising-edge clock
//   rst_n     asynchronous active-low reset
//   CEN       active-low enable (1 = whole pipeline frozen)
//   flush     synchronous clear of every valid bit, wins over CEN
//   in_valid  qualifies data_in / tw_in
//   data_in   lane1 = [127:64], lane0 = [63:0]
//   tw_in     twiddle pair, same lane mapping
//   out_valid data_out valid
//   data_out  lane-wise residues, each in [0, p)
module tw_modmul_2lane #(
  parameter int unsigned P_WIDTH = 128,
  parameter int unsigned LANE_W  = 64,
  parameter logic [63:0] MODULUS = 64'hFFFFFFFF00000001
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               CEN,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] data_in,
  input  logic [P_WIDTH-1:0] tw_in,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] data_out
);

  localparam int unsigned NLANES = P_WIDTH / LANE_W;
  localparam int unsigned HW     = LANE_W / 2;
  localparam int unsigned XW     = 2 * LANE_W;
  // 2^32 - 1 == 2^64 mod p: the correction applied on every wrap
  localparam logic [LANE_W-1:0] EPS = {{HW{1'b0}}, {HW{1'b1}}};

  // Full 128-bit product from four 32x32 partial products
  function automatic logic [XW-1:0] f_mul(input logic [LANE_W-1:0] a,
                                          input logic [LANE_W-1:0] b);
    logic [LANE_W-1:0] ll, lh, hl, hh;
    logic [LANE_W:0]   mid;
    ll  = LANE_W'(a[HW-1:0])      * LANE_W'(b[HW-1:0]);
    lh  = LANE_W'(a[HW-1:0])      * LANE_W'(b[LANE_W-1:HW]);
    hl  = LANE_W'(a[LANE_W-1:HW]) * LANE_W'(b[HW-1:0]);
    hh  = LANE_W'(a[LANE_W-1:HW]) * LANE_W'(b[LANE_W-1:HW]);
    mid = (LANE_W+1)'(lh) + (LANE_W+1)'(hl);
    return {hh, ll} + (XW'(mid) << HW);
  endfunction

  // Fold x = x0 + x1*2^64 + x2*2^96 using 2^64 = 2^32-1, 2^96 = -1 (mod p).
  // Returns {u, t}; a borrow in x0 - x2 is repaired by adding p, i.e.
  // subtracting 2^32-1 from the 2^64-wrapped difference.
  function automatic logic [XW-1:0] f_fold(input logic [XW-1:0] x);
    logic [LANE_W:0]   d;
    logic [LANE_W-1:0] t, u;
    logic [HW-1:0]     x1, x2;
    x1 = x[LANE_W+HW-1:LANE_W];
    x2 = x[XW-1:LANE_W+HW];
    d  = {1'b0, x[LANE_W-1:0]} - (LANE_W+1)'(x2);
    t  = d[LANE_W] ? (d[LANE_W-1:0] - EPS) : d[LANE_W-1:0];
    u  = {x1, {HW{1'b0}}} - LANE_W'(x1);
    return {u, t};
  endfunction

  // t + u < 2^65; a carry is worth 2^32-1, after which one conditional
  // subtract of p is enough since the sum is below 2p.
  function automatic logic [LANE_W-1:0] f_final(input logic [LANE_W-1:0] t,
                                                input logic [LANE_W-1:0] u);
    logic [LANE_W:0]   s;
    logic [LANE_W-1:0] r;
    s = (LANE_W+1)'(t) + (LANE_W+1)'(u);
    r = s[LANE_W] ? (s[LANE_W-1:0] + EPS) : s[LANE_W-1:0];
    return (r >= MODULUS) ? (r - MODULUS) : r;
  endfunction

  logic [P_WIDTH-1:0]             r_s1_a, r_s1_b;
  logic [NLANES-1:0][XW-1:0]      r_s2_x;
  logic [NLANES-1:0][LANE_W-1:0]  r_s3_t, r_s3_u;
  logic                           r_s1_v, r_s2_v, r_s3_v;

  logic [NLANES-1:0][XW-1:0]      w_prod;
  logic [NLANES-1:0][LANE_W-1:0]  w_t, w_u;
  logic [P_WIDTH-1:0]             w_res;

  // Per-lane datapath between the stage registers; lanes never interact
  always_comb begin
    w_prod = '0;
    w_t    = '0;
    w_u    = '0;
    w_res  = '0;
    for (int l = 0; l < NLANES; l++) begin
      w_prod[l] = f_mul(r_s1_a[l*LANE_W +: LANE_W], r_s1_b[l*LANE_W +: LANE_W]);
      {w_u[l], w_t[l]} = f_fold(r_s2_x[l]);
      w_res[l*LANE_W +: LANE_W] = f_final(r_s3_t[l], r_s3_u[l]);
    end
  end

  // Stage registers: valid chain honours flush first, then CEN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s2_x    <= '0;
      r_s3_t    <= '0;
      r_s3_u    <= '0;
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      if (flush) begin
        r_s1_v    <= 1'b0;
        r_s2_v    <= 1'b0;
        r_s3_v    <= 1'b0;
        out_valid <= 1'b0;
      end else if (!CEN) begin
        r_s1_v    <= in_valid;
        r_s2_v    <= r_s1_v;
        r_s3_v    <= r_s2_v;
        out_valid <= r_s3_v;
      end
      if (!CEN) begin
        r_s1_a <= data_in;
        r_s1_b <= tw_in;
        r_s2_x <= w_prod;
        r_s3_t <= w_t;
        r_s3_u <= w_u;
        // data_out only moves with a real result so it holds across bubbles
        if (r_s3_v && !flush) begin
          data_out <= w_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_tw_modmul_2lane.sv
// Directed bench for tw_modmul_2lane: fixed vectors with hand-derived
// residues, a CEN-stalled twiddle stream checked against a %-based model,
// flush behaviour and asynchronous reset.
module tb_tw_modmul_2lane;

  localparam logic [63:0]  P    = 64'hFFFFFFFF00000001;
  localparam logic [127:0] TW64 = 128'h007fffffffffff80_3babf8a70b9016d7;

  logic         CLK;
  logic         rst_n;
  logic         CEN;
  logic         flush;
  logic         in_valid;
  logic [127:0] data_in;
  logic [127:0] tw_in;
  logic         out_valid;
  logic [127:0] data_out;

  int n_checks;
  int n_errors;

  tw_modmul_2lane dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .CEN       (CEN),
    .flush     (flush),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .tw_in     (tw_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: reduce operands first, multiply wide, reduce again
  function automatic logic [63:0] ref_mm(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] aa, bb, pp;
    aa = 128'(a % P);
    bb = 128'(b % P);
    pp = aa * bb;
    return 64'(pp % 128'(P));
  endfunction

  // Drives one beat at a negedge and samples out_valid/data_out after
  // edges 3, 4 and 5 counted from the capturing edge.
  task automatic send_single(input logic [127:0] d, input logic [127:0] t,
                             output logic v3, output logic v4, output logic [127:0] q4,
                             output logic v5, output logic [127:0] q5);
    @(negedge CLK);
    CEN = 1'b0; flush = 1'b0; in_valid = 1'b1; data_in = d; tw_in = t;
    @(negedge CLK);
    in_valid = 1'b0; data_in = '0; tw_in = '0;
    @(negedge CLK);
    @(negedge CLK);
    v3 = out_valid;
    @(negedge CLK);
    v4 = out_valid; q4 = data_out;
    @(negedge CLK);
    v5 = out_valid; q5 = data_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; CEN = 1'b0; flush = 1'b0; in_valid = 1'b1;
    data_in = {64'd5, 64'd6}; tw_in = {64'd7, 64'd8};
    repeat (3) @(negedge CLK);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    n_checks++;
    if (data_out !== 128'd0) begin
      n_errors++; $display("FAIL reset_data: got %h want 0", data_out);
    end
    in_valid = 1'b0; data_in = '0; tw_in = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic v3, v4, v5;
    logic [127:0] q4, q5;
    send_single({64'h1, 64'h1}, {64'h1, 64'h1}, v3, v4, q4, v5, q5);
    n_checks++;
    if (v3 !== 1'b0) begin n_errors++; $display("FAIL single_early: got %0b want 0", v3); end
    n_checks++;
    if (v4 !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %0b want 1", v4); end
    n_checks++;
    if (q4 !== {64'h1, 64'h1}) begin n_errors++; $display("FAIL single_data: got %h want %h", q4, {64'h1, 64'h1}); end
    n_checks++;
    if (v5 !== 1'b0) begin n_errors++; $display("FAIL single_pulse: got %0b want 0", v5); end
    n_checks++;
    if (q5 !== {64'h1, 64'h1}) begin n_errors++; $display("FAIL single_hold: got %h want %h", q5, {64'h1, 64'h1}); end
  endtask

  task automatic test_edge_values();
    logic v3, v4, v5;
    logic [127:0] q4, q5;
    send_single({P - 64'd1, P - 64'd1}, {P - 64'd1, 64'd2}, v3, v4, q4, v5, q5);
    n_checks++;
    if (v4 !== 1'b1 || q4 !== {64'h1, 64'hFFFFFFFEFFFFFFFF}) begin
      n_errors++; $display("FAIL edge_values: got v=%0b %h want v=1 %h", v4, q4, {64'h1, 64'hFFFFFFFEFFFFFFFF});
    end
  endtask

  task automatic test_pow2();
    logic v3, v4, v5;
    logic [127:0] q4, q5;
    send_single({64'h0000000100000000, 64'h0001000000000000},
                {64'h0000000100000000, 64'h0001000000000000}, v3, v4, q4, v5, q5);
    n_checks++;
    if (v4 !== 1'b1 || q4 !== {64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000}) begin
      n_errors++; $display("FAIL pow2_fold: got v=%0b %h want v=1 %h", v4, q4, {64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000});
    end
  endtask

  task automatic test_noncanon();
    logic v3, v4, v5;
    logic [127:0] q4, q5;
    send_single({P + 64'd5, 64'hFFFFFFFFFFFFFFFF}, {64'd3, 64'd1}, v3, v4, q4, v5, q5);
    n_checks++;
    if (v4 !== 1'b1 || q4 !== {64'd15, 64'h00000000FFFFFFFE}) begin
      n_errors++; $display("FAIL noncanon: got v=%0b %h want v=1 %h", v4, q4, {64'd15, 64'h00000000FFFFFFFE});
    end
  endtask

  // 16 beats against the BC=64 twiddle pair with a 3-cycle CEN stall;
  // junk with in_valid=1 is offered during the stall and must be ignored.
  task automatic test_stream_cen();
    logic [127:0] exp_q[$];
    logic [127:0] exp, d, hold_d;
    logic         hold_v, cen_prev;
    int           sent, n_rx;
    sent = 0; n_rx = 0; cen_prev = 1'b0; hold_v = 1'b0; hold_d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        if (!cen_prev) begin
          if (out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_errors++; $display("FAIL stream_extra: got %h want none", data_out);
            end else begin
              exp = exp_q.pop_front();
              if (data_out !== exp) begin
                n_errors++; $display("FAIL stream_data[%0d]: got %h want %h", n_rx, data_out, exp);
              end
            end
            n_rx++;
          end
        end else begin
          n_checks++;
          if (out_valid !== hold_v || data_out !== hold_d) begin
            n_errors++; $display("FAIL stream_freeze: got v=%0b %h want v=%0b %h", out_valid, data_out, hold_v, hold_d);
          end
        end
        hold_v = out_valid; hold_d = data_out;
      end
      CEN = (i >= 6 && i <= 8);
      if (CEN) begin
        in_valid = 1'b1; data_in = {$urandom, $urandom, $urandom, $urandom}; tw_in = TW64;
      end else if (sent < 16) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        if (sent == 0) d = {P - 64'd1, 64'hFFFFFFFFFFFFFFFF};
        in_valid = 1'b1; data_in = d; tw_in = TW64;
        exp_q.push_back({ref_mm(d[127:64], TW64[127:64]), ref_mm(d[63:0], TW64[63:0])});
        sent++;
      end else begin
        in_valid = 1'b0; data_in = '0; tw_in = '0;
      end
      cen_prev = CEN;
    end
    CEN = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (n_rx != 16 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL stream_count: got %0d results want 16", n_rx);
    end
  endtask

  task automatic test_flush();
    logic v3, v4, v5;
    logic [127:0] q4, q5;
    // three beats in flight, then flush together with a new sample
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      CEN = 1'b0; in_valid = 1'b1; data_in = {64'(i + 2), 64'(i + 3)}; tw_in = {64'd2, 64'd2};
    end
    @(negedge CLK);
    flush = 1'b1; in_valid = 1'b1; data_in = {64'd9, 64'd9}; tw_in = {64'd9, 64'd9};
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++; $display("FAIL flush_valid[%0d]: got %0b want 0", i, out_valid);
      end
    end
    // flush while frozen still clears the valid bits
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; data_in = {64'd4, 64'd4}; tw_in = {64'd4, 64'd4};
    end
    @(negedge CLK);
    CEN = 1'b1; flush = 1'b1; in_valid = 1'b0;
    @(negedge CLK);
    CEN = 1'b0; flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++; $display("FAIL flush_cen_valid[%0d]: got %0b want 0", i, out_valid);
      end
    end
    send_single({64'd3, 64'd7}, {64'd5, 64'd11}, v3, v4, q4, v5, q5);
    n_checks++;
    if (v4 !== 1'b1 || q4 !== {64'd15, 64'd77}) begin
      n_errors++; $display("FAIL flush_recover: got v=%0b %h want v=1 %h", v4, q4, {64'd15, 64'd77});
    end
  endtask

  task automatic test_async_reset();
    logic v3, v4, v5;
    logic [127:0] q4, q5;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      CEN = 1'b0; in_valid = 1'b1; data_in = {64'(i + 1), 64'(i + 2)}; tw_in = {64'd2, 64'd3};
    end
    @(posedge CLK);
    #2;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++; $display("FAIL areset_pre: got %0b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL areset_valid: got %0b want 0", out_valid);
    end
    n_checks++;
    if (data_out !== 128'd0) begin
      n_errors++; $display("FAIL areset_data: got %h want 0", data_out);
    end
    @(negedge CLK);
    in_valid = 1'b0; data_in = '0; tw_in = '0;
    @(negedge CLK);
    rst_n = 1'b1;
    send_single({64'd9, 64'd2}, {64'd4, 64'd1}, v3, v4, q4, v5, q5);
    n_checks++;
    if (v3 !== 1'b0 || v4 !== 1'b1) begin
      n_errors++; $display("FAIL areset_latency: got v3=%0b v4=%0b want 0 1", v3, v4);
    end
    n_checks++;
    if (q4 !== {64'd36, 64'd2}) begin
      n_errors++; $display("FAIL areset_data_after: got %h want %h", q4, {64'd36, 64'd2});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_single();
    test_edge_values();
    test_pow2();
    test_noncanon();
    test_stream_cen();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
